// File: rtl/buff_pkg.sv
// buff_pkg -- shared types and constants for the buff_in_seq IN-buffer sequencer.
//
// Contents:
//   MAX_PKT      largest packet the IN buffer holds (bytes)
//   ADDR_W       IN-buffer byte address width
//   LEN_W        byte count / commit length width
//   TMO_W        idle-flush timer width
//   state_e      sequencer states
//   eff_max_len  maps cfg_max_len onto the usable range 1..MAX_PKT
//
// Optional feature macro: USB_BUFF_ZLP_EN adds the ST_ZLP state.
package buff_pkg;

    localparam int MAX_PKT = 512;
    localparam int ADDR_W  = 9;
    localparam int LEN_W   = 10;
    localparam int TMO_W   = 16;

`ifdef USB_BUFF_ZLP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ZLP    = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;
`endif

    // Zero or anything above the buffer size means "use the whole buffer".
    function automatic logic [LEN_W-1:0] eff_max_len(input logic [LEN_W-1:0] cfg);
        return ((cfg == '0) || (cfg > LEN_W'(MAX_PKT))) ? LEN_W'(MAX_PKT) : cfg;
    endfunction

endpackage

// File: rtl/buff_in_seq_if.sv
// buff_in_seq_if -- byte stream plus IN-buffer handshake bundle.
//
// Signals:
//   s_valid/s_data/s_last/s_ready   byte stream (transfer on s_valid & s_ready)
//   buf_in_ready                    IN buffer free
//   buf_in_addr/data/wren           buffer byte write port
//   buf_in_commit/commit_len        packet hand-over request and length
//   buf_in_commit_ack               buffer has taken the packet
//
// Modports:
//   master  stream source and IN buffer side (environment)
//   slave   the sequencer
interface buff_in_seq_if;
    import buff_pkg::*;

    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_last;
    logic              s_ready;

    logic              buf_in_ready;
    logic [ADDR_W-1:0] buf_in_addr;
    logic [7:0]        buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_commit;
    logic [LEN_W-1:0]  buf_in_commit_len;
    logic              buf_in_commit_ack;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready,
        output buf_in_ready,
        input  buf_in_addr, buf_in_data, buf_in_wren,
        input  buf_in_commit, buf_in_commit_len,
        output buf_in_commit_ack
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready,
        input  buf_in_ready,
        output buf_in_addr, buf_in_data, buf_in_wren,
        output buf_in_commit, buf_in_commit_len,
        input  buf_in_commit_ack
    );

endinterface

// File: rtl/buff_idle_timer.sv
// buff_idle_timer -- idle-flush down-counter for the FILL state.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear_i      force the counter to zero (outside FILL)
//   load_i       reload with timeout_i (every accepted byte)
//   en_i         one idle cycle with bytes pending
//   timeout_i    idle cycles allowed, 0 disables expiry
//   expire_o     terminal count reached while idle; high for one cycle in
//                practice because the sequencer leaves FILL on it
module buff_idle_timer
    import buff_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [TMO_W-1:0] timeout_i,
    output logic             expire_o
);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= timeout_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMO_W'(1);
        end
    end

    // Loaded with N on the last byte, it reaches zero after N idle cycles;
    // the next idle cycle is the flush.
    assign expire_o = en_i && (timeout_i != '0) && (cnt_q == '0);

endmodule

// File: rtl/buff_in_seq.sv
// buff_in_seq -- packs a byte stream into IN-buffer packets and commits them.
//
// Ports:
//   ext_clk, reset_n   clock, async active-low reset
//   bus                stream + IN-buffer handshake (buff_in_seq_if.slave)
//   stat_configured    device configured; dropping it aborts the packet
//   cfg_max_len        max packet bytes (0 or >512 means 512)
//   cfg_timeout        idle cycles before a partial packet is flushed, 0=off
//   busy               sequencer not idle
//   pkt_count          commits acknowledged (wraps)
//   drop_count         packets aborted by deconfiguration (saturates)
//
// Optional feature macro: USB_BUFF_ZLP_EN -- a full-size packet ended by
// s_last is followed by a zero-length commit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a free buffer; first cycle after a commit skipped
// ST_FILL   | accepting bytes, writing them to the buffer
// ST_COMMIT | commit/commit_len held until acknowledged
// ST_ZLP    | zero-length commit after a full packet (USB_BUFF_ZLP_EN)
module buff_in_seq
    import buff_pkg::*;
(
    input  logic             ext_clk,
    input  logic             reset_n,
    buff_in_seq_if.slave     bus,
    input  logic             stat_configured,
    input  logic [LEN_W-1:0] cfg_max_len,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             busy,
    output logic [15:0]      pkt_count,
    output logic [7:0]       drop_count
);

    state_e            state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  max_q;
    logic              guard_q;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              commit_q;
    logic [LEN_W-1:0]  len_q;
    logic [15:0]       pkt_q;
    logic [7:0]        drop_q;
`ifdef USB_BUFF_ZLP_EN
    logic              zlp_pend_q;
`endif

    logic              s_ready;
    logic              xfer;
    logic [LEN_W-1:0]  cnt_inc_d;
    logic [7:0]        drop_inc_d;
    logic              tmr_en;
    logic              tmr_expire;

    assign s_ready    = (state_q == ST_FILL);
    assign xfer       = bus.s_valid && s_ready;
    assign cnt_inc_d  = cnt_q + LEN_W'(1);
    assign drop_inc_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    assign tmr_en     = (state_q == ST_FILL) && (cnt_q != '0) && !xfer;

    buff_idle_timer u_idle_timer (
        .clk       (ext_clk),
        .rst_n     (reset_n),
        .clear_i   (state_q != ST_FILL),
        .load_i    (xfer),
        .en_i      (tmr_en),
        .timeout_i (cfg_timeout),
        .expire_o  (tmr_expire)
    );

    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            max_q      <= LEN_W'(MAX_PKT);
            guard_q    <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            commit_q   <= 1'b0;
            len_q      <= '0;
            pkt_q      <= '0;
            drop_q     <= '0;
`ifdef USB_BUFF_ZLP_EN
            zlp_pend_q <= 1'b0;
`endif
        end else begin
            wren_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // buf_in_ready may still reflect the packet just handed over.
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (bus.buf_in_ready && stat_configured) begin
                        state_q <= ST_FILL;
                        cnt_q   <= '0;
                        max_q   <= eff_max_len(cfg_max_len);
                    end
                end

                ST_FILL: begin
                    if (!stat_configured) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        if ((cnt_q != '0) || xfer) drop_q <= drop_inc_d;
                    end else if (xfer) begin
                        wren_q <= 1'b1;
                        addr_q <= cnt_q[ADDR_W-1:0];
                        data_q <= bus.s_data;
                        cnt_q  <= cnt_inc_d;
                        if ((cnt_inc_d == max_q) || bus.s_last) begin
                            state_q <= ST_COMMIT;
`ifdef USB_BUFF_ZLP_EN
                            zlp_pend_q <= bus.s_last && (cnt_inc_d == max_q);
`endif
                        end
                    end else if (tmr_expire) begin
                        state_q <= ST_COMMIT;
`ifdef USB_BUFF_ZLP_EN
                        zlp_pend_q <= 1'b0;
`endif
                    end
                end

                ST_COMMIT: begin
                    if (!stat_configured) begin
                        state_q  <= ST_IDLE;
                        commit_q <= 1'b0;
                        len_q    <= '0;
                        cnt_q    <= '0;
                        guard_q  <= 1'b1;
                        if ((cnt_q != '0) || commit_q) drop_q <= drop_inc_d;
                    end else if (!commit_q) begin
                        // Entry cycle overlaps the final write strobe.
                        commit_q <= 1'b1;
                        len_q    <= cnt_q;
                    end else if (bus.buf_in_commit_ack) begin
                        commit_q <= 1'b0;
                        len_q    <= '0;
                        cnt_q    <= '0;
                        pkt_q    <= pkt_q + 16'd1;
                        guard_q  <= 1'b1;
                        state_q  <= ST_IDLE;
`ifdef USB_BUFF_ZLP_EN
                        if (zlp_pend_q) state_q <= ST_ZLP;
`endif
                    end
                end

`ifdef USB_BUFF_ZLP_EN
                ST_ZLP: begin
                    if (!stat_configured) begin
                        state_q    <= ST_IDLE;
                        commit_q   <= 1'b0;
                        len_q      <= '0;
                        cnt_q      <= '0;
                        guard_q    <= 1'b1;
                        zlp_pend_q <= 1'b0;
                        if ((cnt_q != '0) || commit_q) drop_q <= drop_inc_d;
                    end else if (commit_q) begin
                        if (bus.buf_in_commit_ack) begin
                            commit_q   <= 1'b0;
                            pkt_q      <= pkt_q + 16'd1;
                            guard_q    <= 1'b1;
                            zlp_pend_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end else if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (bus.buf_in_ready) begin
                        commit_q <= 1'b1;
                        len_q    <= '0;
                    end
                end
`endif

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready           = s_ready;
    assign bus.buf_in_wren       = wren_q;
    assign bus.buf_in_addr       = addr_q;
    assign bus.buf_in_data       = data_q;
    assign bus.buf_in_commit     = commit_q;
    assign bus.buf_in_commit_len = len_q;
    assign busy                  = (state_q != ST_IDLE);
    assign pkt_count             = pkt_q;
    assign drop_count            = drop_q;

endmodule

// File: tb/tb_buff_in_seq.sv
`timescale 1ns/1ps
module tb_buff_in_seq;
    import buff_pkg::*;

    logic        ext_clk = 1'b0;
    logic        reset_n;
    logic        stat_configured;
    logic [9:0]  cfg_max_len;
    logic [15:0] cfg_timeout;
    logic        busy;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;

    buff_in_seq_if bif ();

    buff_in_seq dut (
        .ext_clk         (ext_clk),
        .reset_n         (reset_n),
        .bus             (bif),
        .stat_configured (stat_configured),
        .cfg_max_len     (cfg_max_len),
        .cfg_timeout     (cfg_timeout),
        .busy            (busy),
        .pkt_count       (pkt_count),
        .drop_count      (drop_count)
    );

    always #5 ext_clk = ~ext_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Buffer-side write log, sampled mid-cycle.
    logic [8:0] wr_addr[$];
    logic [7:0] wr_data[$];
    always @(negedge ext_clk) begin
        if (bif.buf_in_wren === 1'b1) begin
            wr_addr.push_back(bif.buf_in_addr);
            wr_data.push_back(bif.buf_in_data);
        end
    end

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    // Sends n bytes (data = i*7 + seed); s_valid is left high on return.
    task automatic send_pkt(input int n, input bit last_at_end, input logic [7:0] seed,
                            input string name);
        int stalls = 0;
        for (int i = 0; i < n; i++) begin
            bit done = 1'b0;
            bif.s_valid = 1'b1;
            bif.s_data  = 8'(i * 7) + seed;
            bif.s_last  = last_at_end && (i == n - 1);
            for (int w = 0; w < 50 && !done; w++) begin
                if (bif.s_ready === 1'b1) done = 1'b1;
                tick();
            end
            if (!done) stalls++;
        end
        bif.s_last = 1'b0;
        n_checks++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL %s_accept: %0d bytes never accepted, want 0", name, stalls);
        end
    endtask

    task automatic wait_commit(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget && cyc < 0; i++) begin
            tick();
            if (bif.buf_in_commit === 1'b1) cyc = i;
        end
    endtask

    task automatic do_ack();
        bif.buf_in_commit_ack = 1'b1;
        tick();
        bif.buf_in_commit_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n               = 1'b0;
        bif.s_valid           = 1'b0;
        bif.s_data            = 8'h00;
        bif.s_last            = 1'b0;
        bif.buf_in_ready      = 1'b1;
        bif.buf_in_commit_ack = 1'b0;
        stat_configured       = 1'b1;
        cfg_max_len           = 10'd64;
        cfg_timeout           = 16'd0;
        repeat (3) tick();
        n_checks++; if (bif.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", bif.s_ready); end
        n_checks++; if (bif.buf_in_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", bif.buf_in_wren); end
        n_checks++; if (bif.buf_in_commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", bif.buf_in_commit); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (bif.buf_in_addr !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bif.buf_in_addr); end
        n_checks++; if (bif.buf_in_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", bif.buf_in_data); end
        n_checks++; if (bif.buf_in_commit_len !== 10'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", bif.buf_in_commit_len); end
        n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt: got %0d want 0", pkt_count); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_max_len();
        int base = wr_addr.size();
        int cyc, errs = 0;
        send_pkt(64, 1'b0, 8'h10, "maxlen");
        bif.s_valid = 1'b0;
        wait_commit(10, cyc);
        n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL maxlen_commit_delay: got %0d want 1", cyc); end
        n_checks++; if (wr_addr.size() - base != 64) begin n_fail++; $display("FAIL maxlen_wren_count: got %0d want 64", wr_addr.size() - base); end
        if (wr_addr.size() - base == 64) begin
            for (int i = 0; i < 64; i++) begin
                logic [7:0] d = 8'(i * 7) + 8'h10;
                if (wr_addr[base + i] !== 9'(i) || wr_data[base + i] !== d) errs++;
            end
            n_checks++; if (errs != 0) begin n_fail++; $display("FAIL maxlen_addr_data: got %0d bad writes want 0", errs); end
        end
        n_checks++; if (bif.buf_in_commit_len !== 10'd64) begin n_fail++; $display("FAIL maxlen_len: got %0d want 64", bif.buf_in_commit_len); end
        do_ack();
        n_checks++; if (bif.buf_in_commit !== 1'b0) begin n_fail++; $display("FAIL maxlen_commit_drop: got %b want 0", bif.buf_in_commit); end
        n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL maxlen_pkt: got %0d want 1", pkt_count); end
    endtask

    task automatic test_last();
        int base, cyc;
        cfg_max_len = 10'd512;
        base = wr_addr.size();
        send_pkt(10, 1'b1, 8'h33, "last");
        bif.s_valid = 1'b0;
        wait_commit(10, cyc);
        n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL last_commit_delay: got %0d want 1", cyc); end
        n_checks++; if (bif.buf_in_commit_len !== 10'd10) begin n_fail++; $display("FAIL last_len: got %0d want 10", bif.buf_in_commit_len); end
        n_checks++; if (wr_addr.size() - base != 10) begin n_fail++; $display("FAIL last_wren_count: got %0d want 10", wr_addr.size() - base); end
        do_ack();
        n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL last_pkt: got %0d want 2", pkt_count); end
    endtask

    task automatic test_timeout();
        int cyc, seen = 0;
        cfg_timeout = 16'd100;
        send_pkt(5, 1'b0, 8'h50, "tmo");
        bif.s_valid = 1'b0;
        // 100 idle cycles counted, one edge into COMMIT, one for the registered commit.
        wait_commit(300, cyc);
        n_checks++; if (cyc != 102) begin n_fail++; $display("FAIL tmo_commit_delay: got %0d want 102", cyc); end
        n_checks++; if (bif.buf_in_commit_len !== 10'd5) begin n_fail++; $display("FAIL tmo_len: got %0d want 5", bif.buf_in_commit_len); end
        do_ack();
        n_checks++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL tmo_pkt: got %0d want 3", pkt_count); end

        cfg_timeout = 16'd0;
        send_pkt(5, 1'b0, 8'h60, "notmo");
        bif.s_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (bif.buf_in_commit !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL notmo_commit: got %0d commit cycles want 0", seen); end
        send_pkt(1, 1'b1, 8'h70, "notmo_end");
        bif.s_valid = 1'b0;
        wait_commit(10, cyc);
        n_checks++; if (bif.buf_in_commit_len !== 10'd6 || cyc < 0) begin n_fail++; $display("FAIL notmo_len: got %0d want 6", bif.buf_in_commit_len); end
        do_ack();
        n_checks++; if (pkt_count !== 16'd4) begin n_fail++; $display("FAIL notmo_pkt: got %0d want 4", pkt_count); end
    endtask

    task automatic test_ack_delay();
        int base = wr_addr.size();
        int cyc, bad = 0;
        send_pkt(3, 1'b1, 8'h80, "hold");
        // keep offering a byte: it must not be taken while the commit is open
        bif.s_valid = 1'b1;
        bif.s_data  = 8'hEE;
        wait_commit(10, cyc);
        n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL hold_commit_delay: got %0d want 1", cyc); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bif.buf_in_commit !== 1'b1 || bif.buf_in_commit_len !== 10'd3 || bif.s_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
        n_checks++; if (wr_addr.size() - base != 3) begin n_fail++; $display("FAIL hold_wren_count: got %0d want 3", wr_addr.size() - base); end
        bif.s_valid = 1'b0;
        do_ack();
        n_checks++; if (bif.buf_in_commit !== 1'b0) begin n_fail++; $display("FAIL hold_commit_drop: got %b want 0", bif.buf_in_commit); end
        n_checks++; if (pkt_count !== 16'd5) begin n_fail++; $display("FAIL hold_pkt: got %0d want 5", pkt_count); end
    endtask

    task automatic test_abort();
        int seen = 0;
        send_pkt(3, 1'b0, 8'h90, "abort");
        bif.s_valid     = 1'b0;
        stat_configured = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL abort_drop: got %0d want 1", drop_count); end
        for (int i = 0; i < 20; i++) begin
            if (bif.buf_in_commit !== 1'b0) seen++;
            tick();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_commit: got %0d commit cycles want 0", seen); end
        n_checks++; if (pkt_count !== 16'd5) begin n_fail++; $display("FAIL abort_pkt: got %0d want 5", pkt_count); end
    endtask

    task automatic test_zlp();
        int base, cyc;
        cfg_max_len     = 10'd64;
        stat_configured = 1'b1;
        base = wr_addr.size();
        send_pkt(64, 1'b1, 8'hA0, "zlp");
        bif.s_valid = 1'b0;
        wait_commit(10, cyc);
        n_checks++; if (bif.buf_in_commit_len !== 10'd64 || cyc < 0) begin n_fail++; $display("FAIL zlp_full_len: got %0d want 64", bif.buf_in_commit_len); end
        n_checks++; if (wr_addr.size() - base != 64) begin n_fail++; $display("FAIL zlp_wren_count: got %0d want 64", wr_addr.size() - base); end
        if (wr_addr.size() - base == 64) begin
            n_checks++; if (wr_addr[base] !== 9'd0 || wr_addr[base + 63] !== 9'd63) begin n_fail++; $display("FAIL zlp_addr_range: got %0d..%0d want 0..63", wr_addr[base], wr_addr[base + 63]); end
        end
        do_ack();
        n_checks++; if (pkt_count !== 16'd6) begin n_fail++; $display("FAIL zlp_full_pkt: got %0d want 6", pkt_count); end
`ifdef USB_BUFF_ZLP_EN
        wait_commit(20, cyc);
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL zlp_commit: got no zero-length commit want one"); end
        n_checks++; if (bif.buf_in_commit_len !== 10'd0) begin n_fail++; $display("FAIL zlp_len: got %0d want 0", bif.buf_in_commit_len); end
        do_ack();
        n_checks++; if (bif.buf_in_commit !== 1'b0) begin n_fail++; $display("FAIL zlp_commit_drop: got %b want 0", bif.buf_in_commit); end
        n_checks++; if (pkt_count !== 16'd7) begin n_fail++; $display("FAIL zlp_pkt: got %0d want 7", pkt_count); end
`else
        wait_commit(50, cyc);
        n_checks++; if (cyc >= 0) begin n_fail++; $display("FAIL nozlp_commit: got commit after %0d cycles want none", cyc); end
        n_checks++; if (pkt_count !== 16'd6) begin n_fail++; $display("FAIL nozlp_pkt: got %0d want 6", pkt_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_max_len();
        test_last();
        test_timeout();
        test_ack_delay();
        test_abort();
        test_zlp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
